// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
// Module      : imem_responder
// Description : Instruction-memory fetch responder with fixed read latency,
//               response FIFO for stalls, flush and program-load write port.
//               Optional macro IMEM_MISALIGN_ERR_EN adds rsp_err output.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1,
  parameter int DEPTH   = LATENCY + 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        flush,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] rsp_addr,
`ifdef IMEM_MISALIGN_ERR_EN
  output logic        rsp_err,
`endif
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data
);

  localparam int NSTG = LATENCY - 1;
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int PW   = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [31:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] rd_idx;
  logic [ADDR_W-1:0] wr_idx;
  logic [31:0]       rd_word;
  logic              accept;
  logic [31:0]       in_data;
  logic              in_err;

  logic              push;
  logic [31:0]       push_data;
  logic [31:0]       push_addr;
  logic              push_err;
  logic              pop;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [31:0]       fd_q [DEPTH];
  logic [31:0]       fa_q [DEPTH];
  logic              fe_q [DEPTH];
  logic [PW-1:0]     rd_ptr_q, wr_ptr_q, wr_slot;
  logic [CW-1:0]     fcnt_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign rd_idx    = req_addr[ADDR_W+1:2];
  assign wr_idx    = wr_addr[ADDR_W+1:2];
  assign req_ready = (cnt_q < DEPTH_C);
  assign accept    = req_valid && req_ready;

  // Write-first: a same-edge write to the fetched word is forwarded.
  assign rd_word = (wr_en && (wr_idx == rd_idx)) ? wr_data : mem[rd_idx];

`ifdef IMEM_MISALIGN_ERR_EN
  assign in_err  = |req_addr[1:0];
  assign in_data = in_err ? 32'h0 : rd_word;
`else
  assign in_err  = 1'b0;
  assign in_data = rd_word;
`endif

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  generate
    if (NSTG == 0) begin : g_direct
      assign push      = accept;
      assign push_data = in_data;
      assign push_addr = req_addr;
      assign push_err  = in_err;
    end else begin : g_pipe
      logic        pv_q [NSTG];
      logic [31:0] pd_q [NSTG];
      logic [31:0] pa_q [NSTG];
      logic        pe_q [NSTG];

      // Stage 0 always takes the current accept, so it survives a flush.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < NSTG; i++) begin
            pv_q[i] <= 1'b0;
          end
        end else begin
          pv_q[0] <= accept;
          for (int i = 1; i < NSTG; i++) begin
            pv_q[i] <= flush ? 1'b0 : pv_q[i-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        pd_q[0] <= in_data;
        pa_q[0] <= req_addr;
        pe_q[0] <= in_err;
        for (int i = 1; i < NSTG; i++) begin
          pd_q[i] <= pd_q[i-1];
          pa_q[i] <= pa_q[i-1];
          pe_q[i] <= pe_q[i-1];
        end
      end

      assign push      = pv_q[NSTG-1] && !flush;
      assign push_data = pd_q[NSTG-1];
      assign push_addr = pa_q[NSTG-1];
      assign push_err  = pe_q[NSTG-1];
    end
  endgenerate

  assign rsp_valid = (fcnt_q != '0);
  assign pop       = rsp_valid && rsp_ready && !flush;
  assign wr_slot   = flush ? '0 : wr_ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      fcnt_q   <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= push ? PW'(1) : '0;
      fcnt_q   <= push ? CW'(1) : '0;
    end else begin
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      fcnt_q <= fcnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fd_q[wr_slot] <= push_data;
      fa_q[wr_slot] <= push_addr;
      fe_q[wr_slot] <= push_err;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = accept ? CW'(1) : '0;
    end else begin
      cnt_d = cnt_q + CW'(accept) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Head storage is not reset; gating keeps outputs at zero when empty.
  assign rsp_data = rsp_valid ? fd_q[rd_ptr_q] : 32'h0;
  assign rsp_addr = rsp_valid ? fa_q[rd_ptr_q] : 32'h0;

  logic unused_bits;
`ifdef IMEM_MISALIGN_ERR_EN
  assign rsp_err     = rsp_valid && fe_q[rd_ptr_q];
  assign unused_bits = ^{req_addr[31:ADDR_W+2], wr_addr[31:ADDR_W+2], wr_addr[1:0]};
`else
  assign unused_bits = ^{req_addr[31:ADDR_W+2], req_addr[1:0],
                         wr_addr[31:ADDR_W+2], wr_addr[1:0], fe_q[rd_ptr_q]};
`endif

endmodule
`default_nettype wire
